// File: rtl/wasm_pkg.sv
// Shared types for the wasm CPU + memory subsystem: access sizes, memory
// arbiter FSM states and arbiter defaults.
package wasm_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_1B = 2'd0,
        MEM_SIZE_2B = 2'd1,
        MEM_SIZE_4B = 2'd2,
        MEM_SIZE_8B = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2
    } mem_arb_state_t;

    localparam int ARB_MAX_WAIT_DEFAULT = 8;
    localparam logic [7:0] ARB_WAIT_SAT = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ARB_WAIT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wasm_mem_arbiter.sv
// Two-requester arbiter (CPU fixed priority, host starvation-protected) in front of
// the wasm_memory data port. Optional grant statistics under WASM_MEM_ARB_STATS_EN.
//
// state          | meaning
// ARB_IDLE       | no access in flight, arbitrate and grant
// ARB_ISSUE      | latched request presented to memory until accepted
// ARB_WAIT_RESP  | waiting for memory response, routed to owner
module wasm_mem_arbiter
    import wasm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    input  logic              cpu_req_we,
    input  mem_size_t         cpu_req_size,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_trap,

    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    input  logic              host_req_we,
    input  mem_size_t         host_req_size,
    output logic              host_resp_valid,
    output logic [DATA_W-1:0] host_resp_rdata,
    output logic              host_resp_trap,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_req_we,
    output mem_size_t         mem_req_size,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_trap,

`ifdef WASM_MEM_ARB_STATS_EN
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_host_grants,
    output logic [31:0]       stat_host_forced,
`endif
    output logic              busy,
    output logic              proto_err
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    mem_arb_state_t    state_q, state_d;
    logic              owner_q;
    logic [7:0]        wait_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    mem_size_t         size_q;
    logic              proto_err_q;

    logic cpu_win, host_win, resp_hit;

    always_comb begin
        state_d  = state_q;
        cpu_win  = 1'b0;
        host_win = 1'b0;
        resp_hit = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (host_req_valid && (wait_cnt_q >= MAX_WAIT_C || !cpu_req_valid)) begin
                    host_win = 1'b1;
                end else if (cpu_req_valid) begin
                    cpu_win = 1'b1;
                end
                if (cpu_win || host_win) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ARB_WAIT_RESP;
                end
            end
            ARB_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    resp_hit = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            wait_cnt_q  <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= MEM_SIZE_1B;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cpu_win) begin
                owner_q <= 1'b0;
                addr_q  <= cpu_req_addr;
                wdata_q <= cpu_req_wdata;
                we_q    <= cpu_req_we;
                size_q  <= cpu_req_size;
            end else if (host_win) begin
                owner_q <= 1'b1;
                addr_q  <= host_req_addr;
                wdata_q <= host_req_wdata;
                we_q    <= host_req_we;
                size_q  <= host_req_size;
            end
            if (!host_req_valid || host_win) begin
                wait_cnt_q <= 8'd0;
            end else begin
                wait_cnt_q <= sat_inc8(wait_cnt_q);
            end
            // A response strobe outside WAIT_RESP means memory and arbiter disagree.
            if (mem_resp_valid && state_q != ARB_WAIT_RESP) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Readies are masked while reset is held so nothing can be accepted during reset.
    assign cpu_req_ready  = cpu_win  & rst_n;
    assign host_req_ready = host_win & rst_n;

    assign cpu_resp_valid  = resp_hit & ~owner_q;
    assign host_resp_valid = resp_hit &  owner_q;
    assign cpu_resp_rdata  = cpu_resp_valid  ? mem_resp_rdata : '0;
    assign host_resp_rdata = host_resp_valid ? mem_resp_rdata : '0;
    assign cpu_resp_trap   = cpu_resp_valid  & mem_resp_trap;
    assign host_resp_trap  = host_resp_valid & mem_resp_trap;

    assign mem_req_valid = (state_q == ARB_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_we    = we_q;
    assign mem_req_size  = size_q;

    assign busy      = (state_q != ARB_IDLE);
    assign proto_err = proto_err_q;

`ifdef WASM_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_grants  <= 32'd0;
            stat_host_grants <= 32'd0;
            stat_host_forced <= 32'd0;
        end else begin
            if (cpu_win) begin
                stat_cpu_grants <= stat_cpu_grants + 32'd1;
            end
            if (host_win) begin
                stat_host_grants <= stat_host_grants + 32'd1;
            end
            // Host only beats a valid CPU request through the wait threshold.
            if (host_win && cpu_req_valid) begin
                stat_host_forced <= stat_host_forced + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wasm_mem_arbiter.sv
// Directed bench for wasm_mem_arbiter: bench acts as memory, expected responses
// queued at request time and popped when a response strobe appears.
module tb_wasm_mem_arbiter;
    import wasm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [63:0] cpu_req_wdata;
    mem_size_t   cpu_req_size;
    logic        cpu_resp_valid, cpu_resp_trap;
    logic [63:0] cpu_resp_rdata;
    logic        host_req_valid, host_req_ready, host_req_we;
    logic [31:0] host_req_addr;
    logic [63:0] host_req_wdata;
    mem_size_t   host_req_size;
    logic        host_resp_valid, host_resp_trap;
    logic [63:0] host_resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    mem_size_t   mem_req_size;
    logic        mem_resp_valid, mem_resp_trap;
    logic [63:0] mem_resp_rdata;
    logic        busy, proto_err;
`ifdef WASM_MEM_ARB_STATS_EN
    logic [31:0] stat_cpu_grants, stat_host_grants, stat_host_forced;
`endif

    wasm_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_we(cpu_req_we), .cpu_req_size(cpu_req_size),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .cpu_resp_trap(cpu_resp_trap),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_req_we(host_req_we), .host_req_size(host_req_size),
        .host_resp_valid(host_resp_valid), .host_resp_rdata(host_resp_rdata),
        .host_resp_trap(host_resp_trap),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_we(mem_req_we), .mem_req_size(mem_req_size),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_trap(mem_resp_trap),
`ifdef WASM_MEM_ARB_STATS_EN
        .stat_cpu_grants(stat_cpu_grants), .stat_host_grants(stat_host_grants),
        .stat_host_forced(stat_host_forced),
`endif
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          owner;
        logic [63:0] rdata;
        bit          trap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        cpu_req_valid  = 1'b0;
        host_req_valid = 1'b0;
    endtask

    task automatic drive_req(input bit who, input logic [31:0] a, input logic [63:0] wd,
                             input bit we, input mem_size_t sz);
        if (who) begin
            host_req_valid = 1'b1; host_req_addr = a; host_req_wdata = wd;
            host_req_we = we; host_req_size = sz;
        end else begin
            cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_wdata = wd;
            cpu_req_we = we; cpu_req_size = sz;
        end
    endtask

    // Called #1 after the bench drives a memory response.
    task automatic check_resp();
        exp_t e;
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("cpu_resp_valid", cpu_resp_valid, !e.owner);
            chk("host_resp_valid", host_resp_valid, e.owner);
            chk("resp_rdata", e.owner ? host_resp_rdata : cpu_resp_rdata, e.rdata);
            chk("resp_trap", e.owner ? host_resp_trap : cpu_resp_trap, e.trap);
        end
    endtask

    task automatic run_txn(input bit who, input logic [31:0] a, input logic [63:0] wd,
                           input bit we, input mem_size_t sz, input logic [63:0] rd,
                           input bit trap, input int stall, input bit poke);
        @(negedge clk);
        drive_req(who, a, wd, we, sz);
        sb.push_back('{who, rd, trap});
        #1;
        chk("grant_ready", who ? host_req_ready : cpu_req_ready, 1);
        chk("other_ready", who ? cpu_req_ready : host_req_ready, 0);
        @(negedge clk);
        clear_req();
        #1;
        chk("issue_valid", mem_req_valid, 1);
        chk("issue_addr", mem_req_addr, a);
        chk("issue_wdata", mem_req_wdata, wd);
        chk("issue_we", mem_req_we, we);
        chk("issue_size", mem_req_size, sz);
        chk("issue_busy", busy, 1);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                cpu_req_valid  = 1'b1;
                host_req_valid = 1'b1;
            end
            #1;
            chk("stall_cpu_ready", cpu_req_ready, 0);
            chk("stall_host_ready", host_req_ready, 0);
            @(negedge clk);
            #1;
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_addr", mem_req_addr, a);
            chk("stall_wdata", mem_req_wdata, wd);
        end
        clear_req();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        mem_resp_trap  = trap;
        #1;
        check_resp();
        chk("wait_no_req", mem_req_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_trap  = 1'b0;
        #1;
        chk("after_cpu_resp", cpu_resp_valid, 0);
        chk("after_host_resp", host_resp_valid, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_we = 1'b0; cpu_req_size = MEM_SIZE_1B;
        host_req_addr = '0; host_req_wdata = '0; host_req_we = 1'b0; host_req_size = MEM_SIZE_1B;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_trap = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_cpu_ready", cpu_req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: plain CPU load
        run_txn(1'b0, 32'h100, 64'h0, 1'b0, MEM_SIZE_4B, 64'hDEADBEEF, 1'b0, 0, 1'b0);

        // 2: contention; a 3-cycle turnaround gives host wait counts 0,3,6,9 at
        // successive IDLE cycles, so the 4th grant goes to host, then CPU resumes.
        @(negedge clk);
        drive_req(1'b0, 32'h200, 64'h0, 1'b0, MEM_SIZE_8B);
        drive_req(1'b1, 32'h300, 64'h0, 1'b0, MEM_SIZE_8B);
        for (int k = 0; k < 5; k++) begin
            bit exp_host;
            exp_host = (k == 3);
            #1;
            chk("arb_cpu_ready", cpu_req_ready, !exp_host);
            chk("arb_host_ready", host_req_ready, exp_host);
            sb.push_back('{exp_host, 64'hA0 + 64'(k), 1'b0});
            @(negedge clk);
            if (exp_host) host_req_valid = 1'b0;
            mem_req_ready = 1'b1;
            #1;
            chk("arb_addr", mem_req_addr, exp_host ? 32'h300 : 32'h200);
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 64'hA0 + 64'(k);
            #1;
            check_resp();
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
        end
        cpu_req_valid = 1'b0;
`ifdef WASM_MEM_ARB_STATS_EN
        #1;
        chk("stat_host_forced", stat_host_forced, 1);
        chk("stat_cpu_grants", stat_cpu_grants, 5);
`endif

        // 3: memory stalls 5 cycles with both requesters knocking
        run_txn(1'b0, 32'h400, 64'h1122334455667788, 1'b1, MEM_SIZE_8B, 64'h0, 1'b0, 5, 1'b1);

        // 4: host store out of bounds traps, CPU untouched
        run_txn(1'b1, 32'h10000, 64'h55, 1'b1, MEM_SIZE_1B, 64'h0, 1'b1, 0, 1'b0);

        // 5: stray response in IDLE
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h55;
        #1;
        chk("stray_cpu_resp", cpu_resp_valid, 0);
        chk("stray_host_resp", host_resp_valid, 0);
        chk("stray_pre_err", proto_err, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        #1;
        chk("proto_err_set", proto_err, 1);
        run_txn(1'b1, 32'h20, 64'h0, 1'b0, MEM_SIZE_2B, 64'hBEEF, 1'b0, 1, 1'b0);
        chk("proto_err_sticky", proto_err, 1);

        // 6: reset during WAIT_RESP abandons the access
        @(negedge clk);
        drive_req(1'b0, 32'h500, 64'h0, 1'b0, MEM_SIZE_4B);
        @(negedge clk);
        clear_req();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        chk("mid_rst_mem_addr", mem_req_addr, 0);
        chk("mid_rst_cpu_resp", cpu_resp_valid, 0);
        chk("mid_rst_host_resp", host_resp_valid, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 32'h600, 64'h0, 1'b0, MEM_SIZE_4B, 64'hCAFEF00D, 1'b0, 0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
